// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding decode.
// Issues sequential word fetches over a req/gnt/rvalid handshake, tags each grant with its PC,
// buffers returned words in an in-order queue and presents one {pc, inst} pair per cycle.
// A flush redirects the PC and discards queued and in-flight words.
// Optional: define IF_FETCH_STAT_EN to enable the delivered-instruction counter on fetch_cnt_o.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] fetch_cnt_o
);
    localparam int unsigned AW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

    typedef enum logic {StWait, StRun} state_e;

    state_e        r_state, w_state_d;
    logic [31:0]   r_fetch_pc, w_fetch_pc_d;
    logic [CW-1:0] r_outstanding, w_out_d;
    logic [CW-1:0] r_drop, w_drop_d;
    logic [CW-1:0] r_qcount, w_qcount_d;
    logic [AW-1:0] r_q_wptr, r_q_rptr, r_tag_wptr, r_tag_rptr;
    logic [31:0]   r_q_pc   [FQ_DEPTH];
    logic [31:0]   r_q_inst [FQ_DEPTH];
    logic [31:0]   r_tag    [FQ_DEPTH];

    logic w_run, w_credit, w_req, w_grant, w_rsp, w_push, w_pop, w_valid;

    // Handshake decode; credits use registered counts so a same-cycle pop frees nothing.
    always_comb begin
        w_run    = (r_state == StRun);
        w_credit = ({1'b0, r_outstanding} + {1'b0, r_qcount}) < DEPTH_W;
        w_req    = w_run & ~flush_i & w_credit;
        w_grant  = w_req & imem_gnt_i;
        // Words with nothing outstanding are stale leftovers from before a reset.
        w_rsp    = w_run & imem_rvalid_i & (r_outstanding != '0);
        w_push   = w_rsp & (r_drop == '0) & ~flush_i;
        w_valid  = (r_qcount != '0);
        w_pop    = w_valid & ~stall_i & ~flush_i;
    end

    // FSM next state: one idle cycle after reset, then run until the next reset.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StWait:  w_state_d = StRun;
            StRun:   w_state_d = StRun;
            default: w_state_d = StWait;
        endcase
    end

    // Counter and PC next state; flush overrides push, pop and grant.
    always_comb begin
        w_fetch_pc_d = r_fetch_pc;
        w_out_d      = r_outstanding + CW'(w_grant) - CW'(w_rsp);
        w_drop_d     = r_drop;
        w_qcount_d   = r_qcount + CW'(w_push) - CW'(w_pop);
        if (flush_i) begin
            w_fetch_pc_d = flush_pc_i & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old path.
            w_drop_d     = r_outstanding - CW'(w_rsp);
            w_qcount_d   = '0;
        end else begin
            if (w_grant) w_fetch_pc_d = r_fetch_pc + 32'd4;
            if (w_rsp && (r_drop != '0)) w_drop_d = r_drop - CW'(1);
        end
    end

    // State, counters and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StWait;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_qcount      <= '0;
            r_q_wptr      <= '0;
            r_q_rptr      <= '0;
            r_tag_wptr    <= '0;
            r_tag_rptr    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_fetch_pc    <= w_fetch_pc_d;
            r_outstanding <= w_out_d;
            r_drop        <= w_drop_d;
            r_qcount      <= w_qcount_d;
            if (flush_i) begin
                r_q_wptr   <= '0;
                r_q_rptr   <= '0;
                r_tag_wptr <= '0;
                r_tag_rptr <= '0;
            end else begin
                if (w_push)  r_q_wptr   <= r_q_wptr + 1'b1;
                if (w_pop)   r_q_rptr   <= r_q_rptr + 1'b1;
                if (w_grant) r_tag_wptr <= r_tag_wptr + 1'b1;
                // Every kept response consumes the oldest granted tag.
                if (w_push)  r_tag_rptr <= r_tag_rptr + 1'b1;
            end
        end
    end

    // Tag and queue storage; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (w_grant) r_tag[r_tag_wptr] <= r_fetch_pc;
        if (w_push) begin
            r_q_pc[r_q_wptr]   <= r_tag[r_tag_rptr];
            r_q_inst[r_q_wptr] <= imem_rdata_i;
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign inst_valid_o = w_valid;
    assign pc_o         = w_valid ? r_q_pc[r_q_rptr] : 32'h0;
    assign inst_o       = w_valid ? r_q_inst[r_q_rptr] : 32'h0;

`ifdef IF_FETCH_STAT_EN
    logic [31:0] r_fetch_cnt;

    // Count instructions actually handed to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fetch_cnt <= '0;
        else if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end

    assign fetch_cnt_o = r_fetch_cnt;
`else
    assign fetch_cnt_o = 32'h0;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && (r_qcount == DEPTH_W[CW-1:0])));
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed checks of if_fetch against a queue-based reference model.
module tb_if_fetch;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] flush_pc_i, imem_rdata_i;
    logic        imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, pc_o, inst_o, fetch_cnt_o;

    if_fetch #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: plain counters and queues.
    bit          m_run;
    logic [31:0] m_fpc;
    int          m_out, m_drop;
    logic [31:0] q_pc[$], q_inst[$], tags[$];
    logic [31:0] m_cnt;
    // Memory: in-order response queue with per-request due cycle.
    int          mem_due[$];
    logic [31:0] mem_addr[$];
    int          cyc, lat;
    // Expected DUT outputs for the current cycle.
    logic        m_req, m_valid;
    logic [31:0] m_addr, m_pc, m_inst, m_fcnt;

    task automatic model_reset();
        m_run = 0; m_fpc = 32'h0; m_out = 0; m_drop = 0; m_cnt = 32'h0;
        q_pc.delete(); q_inst.delete(); tags.delete();
        mem_due.delete(); mem_addr.delete();
        cyc = 0; lat = 1;
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and form expectations.
    task automatic drive(input logic st, input logic fl, input logic [31:0] fpc, input logic g);
        stall_i = st; flush_i = fl; flush_pc_i = fpc; imem_gnt_i = g;
        if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_addr[0] ^ 32'hA5A5_A5A5;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        m_req   = m_run && !fl && ((m_out + q_pc.size()) < DEPTH);
        m_addr  = m_fpc;
        m_valid = (q_pc.size() > 0);
        m_pc    = m_valid ? q_pc[0] : 32'h0;
        m_inst  = m_valid ? q_inst[0] : 32'h0;
`ifdef IF_FETCH_STAT_EN
        m_fcnt  = m_cnt;
`else
        m_fcnt  = 32'h0;
`endif
        #1;
    endtask

    // Apply the cycle's effects to the model, then move to the next falling edge.
    task automatic advance();
        bit          rv, gr;
        logic [31:0] rd;
        rv = imem_rvalid_i;
        gr = m_req && imem_gnt_i;
        rd = imem_rdata_i;
        if (rv) begin
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
        end
        if (flush_i) begin
            m_out  = m_out - int'(rv);
            m_drop = m_out;
            q_pc.delete(); q_inst.delete(); tags.delete();
            m_fpc  = flush_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (m_valid && !stall_i) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (rv) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else begin
                    q_pc.push_back(tags.pop_front());
                    q_inst.push_back(rd);
                end
            end
            if (gr) begin
                mem_due.push_back(cyc + lat);
                mem_addr.push_back(m_fpc);
                tags.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
                m_out++;
            end
        end
        m_run = 1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        stall_i = 0; flush_i = 0; flush_pc_i = 0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({imem_req_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o, imem_addr_o} !== 130'h0) begin
            n_err++;
            $display("FAIL reset_async req=%b v=%b pc=%h inst=%h cnt=%h addr=%h, want all zero",
                     imem_req_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o, imem_addr_o);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({imem_req_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !== 98'h0) begin
            n_err++;
            $display("FAIL reset_held req=%b v=%b pc=%h inst=%h cnt=%h, want all zero",
                     imem_req_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        bit seen = 0;
        lat = 1;
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL stream c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (i == 1) begin
                n_cmp++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
                    n_err++;
                    $display("FAIL first_req got req=%b addr=%h want 1 00000000",
                             imem_req_o, imem_addr_o);
                end
            end
            if (!seen && m_valid) begin
                seen = 1;
                n_cmp++;
                if (pc_o !== 32'h0 || inst_o !== 32'hA5A5_A5A5) begin
                    n_err++;
                    $display("FAIL first_inst got pc=%h inst=%h want 00000000 a5a5a5a5", pc_o, inst_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc, held_inst;
        lat = 1;
        for (int i = 0; i < 13; i++) begin
            drive(i < 5, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL stall c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (i == 2) begin
                held_pc = pc_o;
                held_inst = inst_o;
            end
            if (i == 4) begin
                n_cmp++;
                if (imem_req_o !== 1'b0 || pc_o !== held_pc || inst_o !== held_inst) begin
                    n_err++;
                    $display("FAIL stall_hold got req=%b pc=%h inst=%h want 0 %h %h",
                             imem_req_o, pc_o, inst_o, held_pc, held_inst);
                end
            end
            advance();
        end
    endtask

    task automatic test_gnt_hold();
        lat = 1;
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b1);
        advance();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 32'h0, i == 5);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL gnt_hold c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (i >= 2 && i <= 5) begin
                n_cmp++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
                    n_err++;
                    $display("FAIL addr_held got req=%b addr=%h want 1 00000010", imem_req_o, imem_addr_o);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (imem_addr_o !== 32'h14) begin
                    n_err++;
                    $display("FAIL addr_adv got %h want 00000014", imem_addr_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        int  waited = 0;
        bit  req_seen = 0, inst_seen = 0;
        lat = 3;
        while (m_out < 2 && waited < 20) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            advance();
            waited++;
        end
        n_cmp++;
        if (m_out != 2) begin
            n_err++;
            $display("FAIL flush_setup in-flight count %0d want 2", m_out);
        end
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        advance();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL flush c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (!req_seen && m_req) begin
                req_seen = 1;
                n_cmp++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
                    n_err++;
                    $display("FAIL flush_addr got req=%b addr=%h want 1 00000100", imem_req_o, imem_addr_o);
                end
            end
            if (!inst_seen && m_valid) begin
                inst_seen = 1;
                n_cmp++;
                if (pc_o !== 32'h100 || inst_o !== (32'h100 ^ 32'hA5A5_A5A5)) begin
                    n_err++;
                    $display("FAIL flush_pc got pc=%h inst=%h want 00000100 a5a5a4a5", pc_o, inst_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_rvalid();
        int  waited = 0;
        bit  hit = 0, inst_seen = 0;
        lat = 1;
        while (!hit && waited < 30) begin
            hit = (q_pc.size() > 0) && (mem_due.size() > 0) && (mem_due[0] <= cyc);
            drive(1'b0, hit, 32'h0000_0200, 1'b1);
            advance();
            waited++;
        end
        n_cmp++;
        if (!hit || inst_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rv hit=%0d valid_after=%b want 1 0", hit, inst_valid_o);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL flush_rv c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (!inst_seen && m_valid) begin
                inst_seen = 1;
                n_cmp++;
                if (pc_o !== 32'h200) begin
                    n_err++;
                    $display("FAIL flush_rv_pc got %h want 00000200", pc_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr[3];
        int          k = 0, pops = 0;
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        lat = 1;
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        advance();
        for (int i = 0; i < 12 && pops < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL wrap c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            if (m_req && k < 3) begin
                n_cmp++;
                if (imem_addr_o !== exp_addr[k]) begin
                    n_err++;
                    $display("FAIL wrap_addr%0d got %h want %h", k, imem_addr_o, exp_addr[k]);
                end
                k++;
            end
            if (m_valid) pops++;
            advance();
        end
        n_cmp++;
`ifdef IF_FETCH_STAT_EN
        if (pops != 3 || fetch_cnt_o !== 32'd3) begin
`else
        if (pops != 3 || fetch_cnt_o !== 32'd0) begin
`endif
            n_err++;
            $display("FAIL wrap_count pops=%0d cnt=%0d want pops 3", pops, fetch_cnt_o);
        end
    endtask

    task automatic test_random();
        logic st, fl, g;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            st = ($urandom_range(0, 3) == 0);
            g  = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            drive(st, fl, $urandom, g);
            n_cmp++;
            if ({imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o} !==
                {m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt}) begin
                n_err++;
                $display("FAIL random c%0d got req=%b a=%h v=%b pc=%h i=%h n=%0d want %b %h %b %h %h %0d",
                         cyc, imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_cnt_o,
                         m_req, m_addr, m_valid, m_pc, m_inst, m_fcnt);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_gnt_hold();
        test_flush();
        test_flush_rvalid();
        test_reset();
        test_wrap();
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Generates the sequential PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small in-order queue and presents one {pc, inst} pair per cycle to decode.
- Supports downstream stall and a flush/redirect that discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
FQ_DEPTH, 2, fetch-queue entries and maximum outstanding-plus-queued words; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
stall_i  input  1  decode cannot accept this cycle
flush_i  input  1  redirect fetch; discard queue and in-flight words
flush_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 00
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address, word aligned
imem_gnt_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  response word valid; responses return in request order, latency >= 1
imem_rdata_i  input  32  response word
inst_valid_o  output  1  pc_o/inst_o hold a real instruction
pc_o  output  32  PC of the presented instruction, to decode pc_i
inst_o  output  32  presented instruction, to decode inst_i
fetch_cnt_o  output  32  delivered-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=WAIT, fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0. Outputs: imem_req_o=0, inst_valid_o=0, pc_o=0, inst_o=0, fetch_cnt_o=0.
- FSM: WAIT -> RUN on the first clock edge after rst deasserts, so the first request is issued in the second cycle. RUN holds until reset. Reset mid-operation abandons all state; responses arriving after reset are not counted (drop=0, queue empty) and are ignored.
- Request rule: imem_req_o = RUN & !flush_i & (outstanding + qcount < FQ_DEPTH), using registered counts. A pop in the same cycle does not free a credit.
- imem_addr_o = fetch_pc. While req=1 and gnt=0, addr is held stable.
- On req & gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding += 1.
- Response rule on rvalid: outstanding -= 1.
  - If drop > 0: drop -= 1, word discarded.
  - Else: push {pc of that request, rdata}. The per-entry PC comes from an in-order tag FIFO of granted addresses.
- Output: queue non-empty -> inst_valid_o=1, pc_o/inst_o = head.
- Queue empty -> inst_valid_o=0, pc_o=0, inst_o=0 (a NOP to decode).
- Pop when inst_valid_o & !stall_i.
- Push and pop in the same cycle are both allowed. A response arriving with the queue empty and stall_i=0 appears at the output the following cycle (1-cycle latency rvalid -> inst_valid_o).
- Queue overflow cannot occur by construction. A push to a full queue is a design error and is flagged by assertion.
- Flush (highest priority; overrides stall, push, and grant):
  - imem_req_o forced 0.
  - Queue and tag FIFO cleared.
  - fetch_pc = {flush_pc_i[31:2], 2'b00}.
  - drop = outstanding - (rvalid & drop==0 ? 1 : 0) + (rvalid & drop>0 ? -1 : 0), i.e. every word still in flight after this cycle is discarded.
  - A response arriving in the flush cycle is discarded.
  - inst_valid_o=0 the cycle after flush. Requests resume the cycle after flush.
- Back-to-back flushes: the second flush overrides the first target; drop is recomputed from the counts current at that time.
- Stall with a full queue: requests stop via credits; outputs hold stable.

Optional Feature:
- Macro IF_FETCH_STAT_EN.
- Defined: fetch_cnt_o is a 32-bit register, reset 0, incremented on each pop (inst_valid_o & !stall_i & !flush_i). Wraps 32'hFFFF_FFFF -> 0.
- Undefined: fetch_cnt_o tied to 32'h0; no counter logic.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle latency, rdata = addr ^ 32'hA5A5_A5A5, no stall -> requests at 0,4,8,... from cycle 2; pc_o=0, inst_o=32'hA5A5_A5A5 one cycle after the first rvalid; then one instruction per cycle.
- Hold stall_i=1 for 5 cycles in steady state -> at most FQ_DEPTH=2 words outstanding/queued; imem_req_o drops; pc_o/inst_o stable; after release, instructions 8,12 delivered with no gaps or duplicates.
- gnt held 0 for 3 cycles with req=1 at addr 32'h10 -> imem_addr_o stays 32'h10; advances to 32'h14 only after gnt.
- Memory latency 3; flush_i with flush_pc_i=32'h0000_0103 while 2 words are in flight -> both late responses dropped; next request addr 32'h100; first delivered pc_o=32'h100.
- Flush in the same cycle as rvalid and a pop -> that word is never presented; inst_valid_o=0 next cycle; no extra word dropped later.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. With IF_FETCH_STAT_EN: fetch_cnt_o=3 after 3 pops; without the macro, fetch_cnt_o stays 0.
